// File: rtl/memory_controller_interface.sv
// Shared types for the memory-controller interface.
// Request/response bundles, FSM states, LFSR step.
package memory_controller_interface;

    localparam int MCI_LINE_BYTES = 16;
    localparam int MCI_LINE_W     = MCI_LINE_BYTES * 8;
    localparam int MCI_ADDR_W     = 32;

    typedef enum logic [1:0] {
        MCI_IDLE,
        MCI_WAIT,
        MCI_RESP
    } mci_mem_state_t;

    // rw = 1 requests a line write, rw = 0 a line read
    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic [MCI_ADDR_W-1:0] addr;
        logic [MCI_LINE_W-1:0] data;
    } mci_request_t;

    typedef struct packed {
        logic                  ready;
        logic [MCI_LINE_W-1:0] data;
    } mci_response_t;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] mci_lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/mci_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first requester at or after ptr, wrapping.
module mci_rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // scan N positions starting from ptr, first hit wins
    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = W'(c);
            end
        end
    end

endmodule

// File: rtl/mci_multiport_mem.sv
// Multi-channel line-granular backing memory.
// Round-robin service, programmable latency, optional jitter.
module mci_multiport_mem
    import memory_controller_interface::*;
#(
    parameter int         N_CH      = 2,
    parameter int         ADDR_W    = 32,
    parameter int         LINE_W    = 128,
    parameter int         DEPTH     = 65536,
    parameter int         MEM_LAT   = 3,
    parameter int         JITTER    = 0,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    localparam int        CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  mci_request_t  mem_req [N_CH],
    output mci_response_t mem_res [N_CH],
    output logic          busy,
    output logic [CH_W-1:0] grant_ch
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MEM_LAT + 4);

    mci_mem_state_t state, state_n;

    logic [CNT_W-1:0]  cnt, cnt_n, cnt_ld;
    logic [N_CH-1:0]   vld, arb_gnt, rdy_q;
    logic [CH_W-1:0]   arb_idx, rr_ptr, gnt_q, cur_ch;
    logic              arb_any, grant, enter_resp;
    logic              lat_rw, cur_rw;
    logic [IDX_W-1:0]  lat_idx, cur_idx;
    logic [LINE_W-1:0] lat_data, cur_data;
    logic [7:0]        lfsr;
    logic [1:0]        jit;
    logic [LINE_W-1:0] dat_q [N_CH];
    logic [LINE_W-1:0] mem [DEPTH];
    logic [N_CH-1:0]   unused_req;
    logic              unused_misc;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign vld[i]        = mem_req[i].valid;
        assign mem_res[i]    = {rdy_q[i], MCI_LINE_W'(dat_q[i])};
        assign unused_req[i] = ^{mem_req[i].addr, mem_req[i].data};
    end

    assign unused_misc = ^{arb_gnt, lfsr, ADDR_W[0]};

    mci_rr_arbiter #(
        .N (N_CH),
        .W (CH_W)
    ) u_arb (
        .req (vld),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign jit    = (JITTER != 0) ? lfsr[1:0] : 2'd0;
    assign cnt_ld = CNT_W'(MEM_LAT - 1) + CNT_W'(jit);
    assign grant  = (state == MCI_IDLE) && arb_any;

    // a fresh grant is taken straight from the inputs, else from latches
    assign cur_ch   = grant ? arb_idx : gnt_q;
    assign cur_rw   = grant ? mem_req[arb_idx].rw : lat_rw;
    assign cur_idx  = grant ? mem_req[arb_idx].addr[OFF_W +: IDX_W] : lat_idx;
    assign cur_data = grant ? LINE_W'(mem_req[arb_idx].data) : lat_data;

    assign enter_resp = (state_n == MCI_RESP) && (state != MCI_RESP);
    assign busy       = (state != MCI_IDLE);
    assign grant_ch   = gnt_q;

    // next state and latency countdown; ready is high during RESP
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            MCI_IDLE: begin
                if (arb_any) begin
                    cnt_n   = cnt_ld;
                    state_n = (cnt_ld == '0) ? MCI_RESP : MCI_WAIT;
                end
            end
            MCI_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = MCI_RESP;
                end
            end
            MCI_RESP: begin
                state_n = MCI_IDLE;
            end
            default: begin
                state_n = MCI_IDLE;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MCI_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // request latch, per-channel response registers, rr pointer, lfsr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_rw   <= 1'b0;
            lat_idx  <= '0;
            lat_data <= '0;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            lfsr     <= LFSR_SEED;
            rdy_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            if (grant) begin
                lat_rw   <= mem_req[arb_idx].rw;
                lat_idx  <= mem_req[arb_idx].addr[OFF_W +: IDX_W];
                lat_data <= LINE_W'(mem_req[arb_idx].data);
                gnt_q    <= arb_idx;
                if (JITTER != 0) begin
                    lfsr <= mci_lfsr_next(lfsr);
                end
            end
            if (enter_resp) begin
                rdy_q[cur_ch] <= 1'b1;
                dat_q[cur_ch] <= cur_rw ? cur_data : mem[cur_idx];
            end
            if (state == MCI_RESP) begin
                rdy_q  <= '0;
                rr_ptr <= (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + CH_W'(1);
            end
        end
    end

    // line write commits on the edge that ends RESP; array is never reset
    always_ff @(posedge clk) begin
        if (state == MCI_RESP && lat_rw) begin
            mem[lat_idx] <= lat_data;
        end
    end

endmodule

// File: tb/tb_mci_multiport_mem.sv
// Directed bench for mci_multiport_mem.
// Vector table plus arbitration, reset and jitter sequences.
module tb_mci_multiport_mem;
    import memory_controller_interface::*;

    logic          clk = 1'b0;
    logic          rst;
    mci_request_t  req  [2];
    mci_response_t res  [2];
    mci_request_t  jreq [2];
    mci_response_t jres [2];
    logic          busy, jbusy;
    logic [0:0]    gch, jgch;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] DB = 128'hdeadbeef;
    localparam logic [127:0] C1 = 128'hc1c1c1c1_c1c1c1c1_c1c1c1c1_c1c1c1c1;
    localparam logic [127:0] PA = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] PB = 128'hffffffff_00000000_5a5a5a5a_00000001;
    localparam logic [127:0] PD = 128'h0badf00d_0badf00d_0badf00d_0badf00d;

    always #5 clk = ~clk;

    mci_multiport_mem #(
        .N_CH(2), .ADDR_W(32), .LINE_W(128), .DEPTH(4096),
        .MEM_LAT(3), .JITTER(0), .LFSR_SEED(8'hA5)
    ) u_dut (
        .clk(clk), .rst(rst), .mem_req(req), .mem_res(res),
        .busy(busy), .grant_ch(gch)
    );

    mci_multiport_mem #(
        .N_CH(2), .ADDR_W(32), .LINE_W(128), .DEPTH(4096),
        .MEM_LAT(3), .JITTER(1), .LFSR_SEED(8'hA5)
    ) u_jit (
        .clk(clk), .rst(rst), .mem_req(jreq), .mem_res(jres),
        .busy(jbusy), .grant_ch(jgch)
    );

    typedef struct {
        int           ch;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input bit j, input int ch, input logic rw,
                          input logic [31:0] a, input logic [127:0] d,
                          output int lat, output logic [127:0] rd,
                          output bit stray);
        mci_request_t r;
        r = '{valid: 1'b1, rw: rw, addr: a, data: d};
        @(posedge clk); #1;
        if (j) jreq[ch] = r;
        else   req[ch]  = r;
        lat   = -1;
        rd    = '0;
        stray = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!j && res[1-ch].ready) stray = 1'b1;
            if (j ? jres[ch].ready : res[ch].ready) begin
                lat = k;
                rd  = j ? jres[ch].data : res[ch].data;
                break;
            end
        end
        if (j) jreq[ch].valid = 1'b0;
        else   req[ch].valid  = 1'b0;
    endtask

    task automatic arb2(input logic [31:0] a0, input logic [31:0] a1,
                        output int t0, output int t1,
                        output logic [127:0] d0, output logic [127:0] d1);
        @(posedge clk); #1;
        req[0] = '{valid: 1'b1, rw: 1'b0, addr: a0, data: '0};
        req[1] = '{valid: 1'b1, rw: 1'b0, addr: a1, data: '0};
        t0 = -1; t1 = -1; d0 = '0; d1 = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (res[0].ready) begin
                t0 = k; d0 = res[0].data; req[0].valid = 1'b0;
            end
            if (res[1].ready) begin
                t1 = k; d1 = res[1].data; req[1].valid = 1'b0;
            end
            if (t0 > 0 && t1 > 0) break;
        end
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
    endtask

    initial begin
        int           lat, t0, t1;
        logic [127:0] rd, d0, d1;
        bit           stray, seen;
        logic [7:0]   m;

        vt[0]  = '{0, 1'b0, 32'h08000, 128'h0, 128'h0};
        vt[1]  = '{0, 1'b1, 32'h08000, DB,     DB};
        vt[2]  = '{1, 1'b0, 32'h08000, 128'h0, DB};
        vt[3]  = '{1, 1'b0, 32'h18000, 128'h0, DB};
        vt[4]  = '{0, 1'b0, 32'h0800C, 128'h0, DB};
        vt[5]  = '{1, 1'b1, 32'h01230, C1,     C1};
        vt[6]  = '{0, 1'b0, 32'h01230, 128'h0, C1};
        vt[7]  = '{0, 1'b1, 32'h0FFF0, PA,     PA};
        vt[8]  = '{1, 1'b0, 32'h0FFF0, 128'h0, PA};
        vt[9]  = '{1, 1'b0, 32'h00000, 128'h0, 128'h0};
        vt[10] = '{0, 1'b1, 32'h00000, PB,     PB};
        vt[11] = '{1, 1'b0, 32'h30000, 128'h0, PB};

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i]  = '{valid: 1'b0, rw: 1'b0, addr: '0, data: '0};
            jreq[i] = '{valid: 1'b0, rw: 1'b0, addr: '0, data: '0};
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset grant_ch", 128'(gch), 128'(0));
        chk("reset ready0", 128'(res[0].ready), 128'(0));
        chk("reset ready1", 128'(res[1].ready), 128'(0));
        chk("reset data0", res[0].data, 128'h0);
        chk("reset data1", res[1].data, 128'h0);
        rst = 1'b1;

        m = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            do_req(1'b1, 0, 1'b0, 32'(i) << 4, '0, lat, rd, stray);
            chk($sformatf("jitter lat %0d", i), 128'(lat),
                128'(3 + int'(m[1:0])));
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        end

        for (int i = 0; i < 12; i++) begin
            do_req(1'b0, vt[i].ch, vt[i].rw, vt[i].addr, vt[i].wd,
                   lat, rd, stray);
            chk($sformatf("vec%0d data", i), rd, vt[i].exp);
            chk($sformatf("vec%0d latency", i), 128'(lat), 128'(3));
            chk($sformatf("vec%0d stray ready", i), 128'(stray), 128'(0));
        end

        arb2(32'h08000, 32'h0FFF0, t0, t1, d0, d1);
        chk("arb1 ch0 cycle", 128'(t0), 128'(3));
        chk("arb1 ch1 cycle", 128'(t1), 128'(7));
        chk("arb1 ch0 data", d0, DB);
        chk("arb1 ch1 data", d1, PA);
        chk("arb1 ch0 data hold", res[0].data, DB);

        do_req(1'b0, 0, 1'b0, 32'h01230, '0, lat, rd, stray);
        chk("single ch0 data", rd, C1);

        arb2(32'h00000, 32'h01230, t0, t1, d0, d1);
        chk("arb2 ch1 cycle", 128'(t1), 128'(3));
        chk("arb2 ch0 cycle", 128'(t0), 128'(7));
        chk("arb2 ch0 data", d0, PB);
        chk("arb2 ch1 data", d1, C1);

        @(posedge clk); #1;
        req[0] = '{valid: 1'b1, rw: 1'b1, addr: 32'h01230, data: PD};
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy in wait", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        chk("midreset busy", 128'(busy), 128'(0));
        chk("midreset ready0", 128'(res[0].ready), 128'(0));
        chk("midreset data0", res[0].data, 128'h0);
        chk("midreset data1", res[1].data, 128'h0);
        req[0].valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (res[0].ready || res[1].ready || busy) seen = 1'b1;
        end
        chk("no ready after reset", 128'(seen), 128'(0));
        do_req(1'b0, 1, 1'b0, 32'h01230, '0, lat, rd, stray);
        chk("abandoned write data", rd, C1);
        chk("post reset latency", 128'(lat), 128'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
